// File: rtl/sound_mixer_if.sv
// Register bus between the host I/O decoder and the sound mixer.
//   address   : 4-bit register address
//   read      : read strobe, qualified by cs
//   write     : write strobe, qualified by cs
//   cs        : mixer chip select
//   writedata : 8-bit write data
//   readdata  : 8-bit registered read data, valid the cycle after cs & read
interface sound_mixer_if;
  logic [3:0] address;
  logic       read;
  logic       write;
  logic       cs;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (
    output address, read, write, cs, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, cs, writedata,
    output readdata
  );
endinterface

// File: rtl/sound_mixer.sv
// Time-multiplexed stereo mixer.
//
// sound_mixer_regs : volume / master / sticky status register file.
// sound_mixer      : frame sequencer, MAC datapath, master gain and saturation.
//
// Top ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   bus               : register bus (slave side)
//   ce_sample         : one-cycle request for a new output frame
//   in_l, in_r        : NCH packed signed samples, channel k at [k*IN_W +: IN_W]
//   sample_l/sample_r : saturated signed output, held between frames
//   sample_valid      : one-cycle pulse while the new output is first presented
//
// Parameters: NCH in 1..7, OUT_W >= IN_W.
// Register map: 0x0..2*NCH-1 channel volumes (even = left, odd = right),
// 0xE master volume, 0xF status {5'b0, overrun, clip_r, clip_l} (read clears).
// Volume gain is vol/128; every volume resets to 0x80 (unity).

module sound_mixer_regs #(
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sound_mixer_if.slave     bus,
  input  logic             clip_l_set,
  input  logic             clip_r_set,
  input  logic             ovr_set,
  output logic [7:0]       vol_l [NCH],
  output logic [7:0]       vol_r [NCH],
  output logic [7:0]       master_vol
);
  localparam logic [3:0] A_MASTER = 4'hE;
  localparam logic [3:0] A_STATUS = 4'hF;

  logic [7:0] vol_l_q [NCH];
  logic [7:0] vol_l_d [NCH];
  logic [7:0] vol_r_q [NCH];
  logic [7:0] vol_r_d [NCH];
  logic [7:0] master_q, master_d;
  logic       clip_l_q, clip_l_d;
  logic       clip_r_q, clip_r_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       wr_en, rd_en, status_clr;

  always_comb begin
    wr_en      = bus.cs & bus.write;
    rd_en      = bus.cs & bus.read;
    status_clr = rd_en & (bus.address == A_STATUS);

    vol_l_d  = vol_l_q;
    vol_r_d  = vol_r_q;
    master_d = master_q;
    if (wr_en) begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.address == 4'(2 * k))     vol_l_d[k] = bus.writedata;
        if (bus.address == 4'(2 * k + 1)) vol_r_d[k] = bus.writedata;
      end
      if (bus.address == A_MASTER) master_d = bus.writedata;
    end

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = 8'h00;
      for (int k = 0; k < NCH; k++) begin
        if (bus.address == 4'(2 * k))     rdata_d = vol_l_q[k];
        if (bus.address == 4'(2 * k + 1)) rdata_d = vol_r_q[k];
      end
      if (bus.address == A_MASTER) rdata_d = master_q;
      if (bus.address == A_STATUS) rdata_d = {5'b00000, ovr_q, clip_r_q, clip_l_q};
    end

    // A new event on the same edge as a clearing read must survive.
    clip_l_d = (clip_l_q & ~status_clr) | clip_l_set;
    clip_r_d = (clip_r_q & ~status_clr) | clip_r_set;
    ovr_d    = (ovr_q    & ~status_clr) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        vol_l_q[k] <= 8'h80;
        vol_r_q[k] <= 8'h80;
      end
      master_q <= 8'h80;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      ovr_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      vol_l_q  <= vol_l_d;
      vol_r_q  <= vol_r_d;
      master_q <= master_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      ovr_q    <= ovr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign vol_l        = vol_l_q;
  assign vol_r        = vol_r_q;
  assign master_vol   = master_q;
  assign bus.readdata = rdata_q;
endmodule

// state  | meaning
// IDLE   | waiting for ce_sample; on it latch inputs and clear accumulators
// ACC    | one channel per cycle added into the L and R accumulators
// MASTER | master gain and saturation; result registered into the outputs
// OUT    | new sample visible with sample_valid high; back to IDLE
module sound_mixer #(
  parameter int NCH   = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sound_mixer_if.slave            bus,
  input  logic                    ce_sample,
  input  logic [NCH*IN_W-1:0]     in_l,
  input  logic [NCH*IN_W-1:0]     in_r,
  output logic signed [OUT_W-1:0] sample_l,
  output logic signed [OUT_W-1:0] sample_r,
  output logic                    sample_valid
);
  localparam int ACC_W = IN_W + 9 + $clog2(NCH + 1);
  localparam int IDX_W = $clog2(NCH + 1);
  localparam int SH    = OUT_W - IN_W;
  localparam int P_W   = IN_W + 9;
  // Wide enough for (acc >>> 7) * master followed by the left shift.
  localparam int W_BIG = ACC_W + 9 + SH;

  localparam logic signed [W_BIG-1:0] SAT_MAX = W_BIG'({(OUT_W-1){1'b1}});
  localparam logic signed [W_BIG-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACC    = 2'd1;
  localparam logic [1:0] S_MASTER = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [7:0] vol_l [NCH];
  logic [7:0] vol_r [NCH];
  logic [7:0] master_vol;
  logic       clip_l_set, clip_r_set, ovr_set;

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [IN_W-1:0]  cap_l_q [NCH];
  logic signed [IN_W-1:0]  cap_l_d [NCH];
  logic signed [IN_W-1:0]  cap_r_q [NCH];
  logic signed [IN_W-1:0]  cap_r_d [NCH];
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0] smp_l_q, smp_l_d;
  logic signed [OUT_W-1:0] smp_r_q, smp_r_d;
  logic                    valid_q, valid_d;

  logic signed [IN_W-1:0]  ch_l, ch_r;
  logic [7:0]              cv_l, cv_r;
  logic signed [P_W-1:0]   prod_l, prod_r;
  logic [OUT_W:0]          mst_l, mst_r;

  sound_mixer_regs #(.NCH(NCH)) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clip_l_set (clip_l_set),
    .clip_r_set (clip_r_set),
    .ovr_set    (ovr_set),
    .vol_l      (vol_l),
    .vol_r      (vol_r),
    .master_vol (master_vol)
  );

  // Returns {clipped, saturated sample}.
  function automatic logic [OUT_W:0] master_sat(input logic signed [ACC_W-1:0] acc,
                                                input logic [7:0] mvol);
    logic signed [W_BIG-1:0] v;
    v = W_BIG'(acc);
    v = v >>> 7;
    v = v * W_BIG'($signed({1'b0, mvol}));
    v = v >>> 7;
    v = v <<< SH;
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    ch_l = '0;
    ch_r = '0;
    cv_l = 8'h00;
    cv_r = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        ch_l = cap_l_q[k];
        ch_r = cap_r_q[k];
        cv_l = vol_l[k];
        cv_r = vol_r[k];
      end
    end
    // Volume is unsigned: zero-extend before the signed multiply.
    prod_l = P_W'(ch_l) * P_W'($signed({1'b0, cv_l}));
    prod_r = P_W'(ch_r) * P_W'($signed({1'b0, cv_r}));
    mst_l  = master_sat(acc_l_q, master_vol);
    mst_r  = master_sat(acc_r_q, master_vol);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_l_d    = cap_l_q;
    cap_r_d    = cap_r_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    smp_l_d    = smp_l_q;
    smp_r_d    = smp_r_q;
    valid_d    = 1'b0;
    clip_l_set = 1'b0;
    clip_r_set = 1'b0;
    ovr_set    = ce_sample & (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ce_sample) begin
          for (int k = 0; k < NCH; k++) begin
            cap_l_d[k] = $signed(in_l[k*IN_W +: IN_W]);
            cap_r_d[k] = $signed(in_r[k*IN_W +: IN_W]);
          end
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_l_d = acc_l_q + ACC_W'(prod_l);
        acc_r_d = acc_r_q + ACC_W'(prod_r);
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCH - 1)) state_d = S_MASTER;
      end
      S_MASTER: begin
        // Outputs load on the way into OUT so they are visible during OUT.
        smp_l_d    = mst_l[OUT_W-1:0];
        smp_r_d    = mst_r[OUT_W-1:0];
        clip_l_set = mst_l[OUT_W];
        clip_r_set = mst_r[OUT_W];
        valid_d    = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        cap_l_q[k] <= '0;
        cap_r_q[k] <= '0;
      end
      acc_l_q <= '0;
      acc_r_q <= '0;
      smp_l_q <= '0;
      smp_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_l_q <= cap_l_d;
      cap_r_q <= cap_r_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      smp_l_q <= smp_l_d;
      smp_r_q <= smp_r_d;
      valid_q <= valid_d;
    end
  end

  assign sample_l     = smp_l_q;
  assign sample_r     = smp_r_q;
  assign sample_valid = valid_q;
endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;
  localparam int NCH   = 4;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ce_sample = 1'b0;
  logic [NCH*IN_W-1:0] in_l = '0;
  logic [NCH*IN_W-1:0] in_r = '0;
  logic signed [OUT_W-1:0] sample_l, sample_r;
  logic sample_valid;

  sound_mixer_if bus();

  sound_mixer #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ce_sample    (ce_sample),
    .in_l         (in_l),
    .in_r         (in_r),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  bit         m_active;
  int         m_ph;          // frame cycle number of the cycle now running
  longint     m_acc_l, m_acc_r;
  longint     m_cap_l [NCH];
  longint     m_cap_r [NCH];
  logic [7:0] m_vol_l [NCH];
  logic [7:0] m_vol_r [NCH];
  logic [7:0] m_master;
  bit         m_clip_l, m_clip_r, m_ovr;
  logic [7:0] m_rd;
  longint     m_out_l, m_out_r;
  bit         m_valid;

  function automatic longint master_stage(input longint acc, input logic [7:0] mv,
                                          output bit clip);
    longint m, hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    m = (acc >>> 7) * longint'(mv);
    m = m >>> 7;
    m = m <<< (OUT_W - IN_W);
    clip = 1'b0;
    if (m > hi) begin m = hi; clip = 1'b1; end
    if (m < lo) begin m = lo; clip = 1'b1; end
    return m;
  endfunction

  function automatic logic [7:0] reg_val(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai < 2 * NCH) return (ai % 2 == 1) ? m_vol_r[ai / 2] : m_vol_l[ai / 2];
    if (ai == 14) return m_master;
    if (ai == 15) return {5'b00000, m_ovr, m_clip_r, m_clip_l};
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit sl, sr, so, clr, started;
    int ai;
    if (!rst_n) begin
      m_active = 0; m_ph = 0; m_acc_l = 0; m_acc_r = 0;
      for (int k = 0; k < NCH; k++) begin
        m_vol_l[k] = 8'h80; m_vol_r[k] = 8'h80; m_cap_l[k] = 0; m_cap_r[k] = 0;
      end
      m_master = 8'h80; m_clip_l = 0; m_clip_r = 0; m_ovr = 0;
      m_rd = 8'h00; m_out_l = 0; m_out_r = 0; m_valid = 0;
    end else begin
      sl = 0; sr = 0; so = 0; clr = 0; started = 0;
      if (bus.cs && bus.read) begin
        m_rd = reg_val(bus.address);
        clr  = (bus.address == 4'hF);
      end
      m_valid = 0;
      if (m_active) begin
        if (m_ph >= 1 && m_ph <= NCH) begin
          m_acc_l += m_cap_l[m_ph-1] * longint'(m_vol_l[m_ph-1]);
          m_acc_r += m_cap_r[m_ph-1] * longint'(m_vol_r[m_ph-1]);
        end
        if (m_ph == NCH + 1) begin
          m_out_l = master_stage(m_acc_l, m_master, sl);
          m_out_r = master_stage(m_acc_r, m_master, sr);
          m_valid = 1;
        end
      end
      if (ce_sample) begin
        if (m_active) so = 1;
        else          started = 1;
      end
      if (m_active) begin
        if (m_ph == NCH + 2) m_active = 0;
        else                 m_ph++;
      end
      if (started) begin
        m_active = 1; m_ph = 1; m_acc_l = 0; m_acc_r = 0;
        for (int k = 0; k < NCH; k++) begin
          m_cap_l[k] = longint'($signed(in_l[k*IN_W +: IN_W]));
          m_cap_r[k] = longint'($signed(in_r[k*IN_W +: IN_W]));
        end
      end
      if (bus.cs && bus.write) begin
        ai = int'(bus.address);
        if (ai < 2 * NCH) begin
          if (ai % 2 == 1) m_vol_r[ai / 2] = bus.writedata;
          else             m_vol_l[ai / 2] = bus.writedata;
        end
        if (ai == 14) m_master = bus.writedata;
      end
      m_clip_l = (m_clip_l && !clr) || sl;
      m_clip_r = (m_clip_r && !clr) || sr;
      m_ovr    = (m_ovr    && !clr) || so;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sample_valid", longint'(sample_valid), longint'(m_valid));
      chk("sample_l", longint'(sample_l), m_out_l);
      chk("sample_r", longint'(sample_r), m_out_r);
      chk("readdata", longint'(bus.readdata), longint'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.read = 1'b1; bus.address = a;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic fire();
    @(posedge clk); #1; ce_sample = 1'b1;
    @(posedge clk); #1; ce_sample = 1'b0;
  endtask

  // Called right after fire(): the first negedge seen is in cycle T+1.
  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) begin seen = 1; lat = i; end
    end
    if (!seen) chk({name, " timeout"}, 0, 1);
    else       chk({name, " latency"}, lat, exp_lat);
  endtask

  function automatic logic [IN_W-1:0] rnd_smp();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return IN_W'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] rd;
    int nv;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = 4'h0; bus.writedata = 8'h00;

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // reset defaults
    for (int a = 0; a < 2 * NCH; a++) begin
      bus_rd(4'(a), rd);
      chk("reset vol", longint'(rd), 128);
    end
    bus_rd(4'hE, rd); chk("reset master", longint'(rd), 128);
    bus_rd(4'hF, rd); chk("reset status", longint'(rd), 0);
    chk("reset sample_l", longint'(sample_l), 0);

    // unity sum
    in_l = '0; in_r = '0;
    in_l[15:0]  = 16'd1000;
    in_l[31:16] = 16'hFF06;           // -250
    fire();
    wait_valid("unity", NCH + 2);
    chk("unity sample_l", longint'(sample_l), 750);
    @(negedge clk);
    chk("unity valid drops", longint'(sample_valid), 0);

    // scaling
    bus_wr(4'h0, 8'h40);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'hE, 8'h80);
    in_l = '0; in_r = '0;
    in_l[15:0] = 16'h4000;
    in_r[15:0] = 16'h4000;
    fire();
    wait_valid("scale", NCH + 2);
    chk("scale sample_l", longint'(sample_l), 32'h2000);
    chk("scale sample_r", longint'(sample_r), 0);

    // saturation and sticky clear
    bus_wr(4'h0, 8'h80);
    bus_wr(4'h1, 8'h80);
    in_l = {NCH{16'h7000}}; in_r = '0;
    fire();
    wait_valid("sat pos", NCH + 2);
    chk("sat pos sample_l", longint'(sample_l), 32767);
    bus_rd(4'hF, rd); chk("clip status", longint'(rd), 1);
    bus_rd(4'hF, rd); chk("clip cleared", longint'(rd), 0);
    in_l = {NCH{16'h9000}};
    fire();
    wait_valid("sat neg", NCH + 2);
    chk("sat neg sample_l", longint'(sample_l), -32768);
    bus_rd(4'hF, rd); chk("clip neg status", longint'(rd), 1);

    // overrun: second request two cycles after the first
    in_l = '0; in_r = '0;
    fire();
    @(posedge clk); #1; ce_sample = 1'b1;
    @(posedge clk); #1; ce_sample = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sample_valid) nv++;
    end
    chk("overrun valid count", nv, 1);
    bus_rd(4'hF, rd); chk("overrun status", longint'(rd), 4);

    // reset mid-frame
    bus_wr(4'h2, 8'h33);
    in_l = {NCH{16'h0100}};
    fire();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid) nv++;
    end
    chk("aborted frame valid", nv, 0);
    chk("aborted sample_l", longint'(sample_l), 0);
    bus_rd(4'h2, rd); chk("vol after reset", longint'(rd), 128);
    in_l = '0; in_l[15:0] = 16'd1000;
    fire();
    wait_valid("post reset", NCH + 2);
    chk("post reset sample_l", longint'(sample_l), 1000);

    // randomized traffic: overruns, mid-frame writes, clearing reads
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(posedge clk); #1;
      ce_sample = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NCH; k++) begin
        in_l[k*IN_W +: IN_W] = rnd_smp();
        in_r[k*IN_W +: IN_W] = rnd_smp();
      end
      bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address   = 4'($urandom_range(0, 15));
      bus.writedata = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 1)      begin bus.cs = 1'b1; bus.write = 1'b1; end
      else if (r <= 3) begin bus.cs = 1'b1; bus.read  = 1'b1; end
      else if (r == 4) begin bus.write = 1'b1; end
    end
    @(posedge clk); #1;
    ce_sample = 1'b0; bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    repeat (NCH + 6) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
